// File: rtl/instr_mem_resp_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
package instr_mem_resp_pkg;

    localparam int INSTR_W      = 32;  // InstrBus
    localparam int INSTR_ADDR_W = 32;  // InstrAddrBus

    localparam logic [31:0] IMR_NOP = 32'h0000_0013;  // addi x0,x0,0

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Wait-state counter covers WAIT_CYC in 0..7
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IMR_IDLE = 2'd0,
        IMR_WAIT = 2'd1,
        IMR_RESP = 2'd2
    } imr_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write and one registered read per clock, no reset.
// A read and write to the same word on one edge returns the old contents.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/instr_mem_resp.sv
// Memory-side fetch responder: latches a PC address, waits WAIT_CYC cycles,
// then presents the instruction (or NOP with an error flag) for one cycle.
module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int                ADDR_W    = INSTR_ADDR_W,
    parameter int                DATA_W    = INSTR_W,
    parameter int                DEPTH     = 1024,
    parameter int                WAIT_CYC  = 1,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IMR_NOP)
) (
    input  logic              clk_i_IMR,
    input  logic              reset_i_IMR,
    input  logic [ADDR_W-1:0] pc_addr_i_IMR,
    input  logic              chip_enable_i_IMR,
    output logic              req_ready_o_IMR,
    output logic [DATA_W-1:0] instr_o_IMR,
    output logic              instr_valid_o_IMR,
    output logic              fetch_err_o_IMR,
    input  logic              load_en_i_IMR,
    input  logic [ADDR_W-1:0] load_addr_i_IMR,
    input  logic [DATA_W-1:0] load_data_i_IMR
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(WAIT_CYC);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    imr_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              accept;
    logic              to_resp;
    logic              use_nop;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    logic              load_lsb_unused;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({2'b00, a[ADDR_W-1:2]} < DEPTH_A);
    endfunction

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || !in_range(a);
    endfunction

    always_comb begin
        state_nxt       = state;
        req_ready_o_IMR = 1'b0;
        accept          = 1'b0;
        to_resp         = 1'b0;
        case (state)
            IMR_IDLE, IMR_RESP: begin
                req_ready_o_IMR = 1'b1;
                state_nxt       = IMR_IDLE;
                if (chip_enable_i_IMR == CHIP_ENABLE) begin
                    accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_nxt = IMR_RESP;
                        to_resp   = 1'b1;
                    end else begin
                        state_nxt = IMR_WAIT;
                    end
                end
            end
            IMR_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IMR_RESP;
                    to_resp   = 1'b1;
                end
            end
            default: state_nxt = IMR_IDLE;
        endcase
    end

    // With no wait states the read is issued on the accept edge, so the
    // live PC address feeds the array; otherwise the latched one does.
    assign rd_addr = (state == IMR_WAIT) ? addr_q : pc_addr_i_IMR;

    always_ff @(posedge clk_i_IMR or negedge reset_i_IMR) begin
        if (!reset_i_IMR) begin
            state   <= IMR_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            use_nop <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= pc_addr_i_IMR;
                cnt    <= WAIT_LD;
            end else if (state == IMR_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (to_resp) use_nop <= addr_bad(rd_addr);
        end
    end

    // Array writes are blocked while reset is held; out-of-range is dropped.
    assign wr_ok           = load_en_i_IMR && reset_i_IMR && in_range(load_addr_i_IMR);
    assign load_lsb_unused = ^load_addr_i_IMR[1:0];

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk_i_IMR),
        .wr_en   (wr_ok),
        .wr_idx  (load_addr_i_IMR[IDX_W+1:2]),
        .wr_data (load_data_i_IMR),
        .rd_en   (to_resp),
        .rd_idx  (rd_addr[IDX_W+1:2]),
        .rd_data (rd_data)
    );

    // use_nop also covers the post-reset state, before any read has landed.
    assign instr_o_IMR       = use_nop ? NOP_INSTR : rd_data;
    assign instr_valid_o_IMR = (state == IMR_RESP);
    assign fetch_err_o_IMR   = (state == IMR_RESP) && use_nop;

endmodule
